alu_result_tx: RTL and testbench
================================

Name: alu_result_tx

Overview:
Transmit sequencer between the ALU result and the UART TX FIFO. On a start pulse it captures the N-bit ALU result and converts it to decimal BCD with an iterative double-dabble engine. It then streams the ASCII digits, with an optional sign and a CR/LF terminator, into the UART TX FIFO one byte per accepted write. It replaces the single-digit "result + 48" transmit path of the UART/ALU interface FSM.

Parameters:
N, 8, ALU result width in bits.
D, 3, number of BCD digits; must satisfy 10^D > 2^N.
SIGNED, 0, 1 = treat the result as two's complement and emit '-' (45) for negatives.
CRLF, 1, 1 = append CR (13) then LF (10) after the last digit.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-low reset (asserted when 0).
start  in  1  one-cycle request; sampled only in IDLE.
alu_in  in  N  ALU result; captured in the cycle start is accepted.
tx_full  in  1  UART TX FIFO full flag.
wr_uart  out  1  TX FIFO write strobe; one byte per cycle when high.
uart_out  out  8  ASCII byte; valid whenever wr_uart=1.
busy  out  1  high from the cycle after start acceptance until the return to IDLE.
done  out  1  one-cycle pulse after the final byte is written.

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; wr_uart=0, uart_out=0, busy=0, done=0; shift/BCD registers cleared.
- Reset is honoured in any state, including mid-conversion and mid-emission.
  - Any partially emitted string is abandoned.
  - No further writes are issued.
- States: IDLE, SIGN, CONV, EMIT, TERM_CR, TERM_LF, DONE.
- IDLE:
  - start=1 captures the magnitude: alu_in, or -alu_in if SIGNED=1 and alu_in[N-1]=1. The magnitude is computed in N bits as unsigned, so 0x80 yields 128.
  - Sets neg_flag, clears BCD, loads iteration counter = N.
  - Next state: SIGN if neg_flag, else CONV.
- SIGN: drives '-' on uart_out.
  - wr_uart = ~tx_full.
  - Advances to CONV on the write cycle; holds while tx_full=1.
- CONV: exactly N cycles. Each cycle:
  - Add 3 to every BCD nibble that is >= 5.
  - Shift {bcd, mag} left by 1.
  - Decrement the counter.
  - Go to EMIT when the counter reaches 0.
  - wr_uart=0 throughout.
- EMIT: digit index k runs from D-1 down to 0.
  - Leading-zero suppression: while no digit has been emitted yet and digit k is 0 and k>0, skip it. This takes one cycle per skipped digit with no write.
  - Otherwise uart_out = digit + 48 and wr_uart = ~tx_full. Advance k only on a write.
  - After k=0 is written: go to TERM_CR if CRLF=1, else DONE.
  - An all-zero result emits exactly one '0'.
- TERM_CR / TERM_LF: emit 13, then 10, each with the same tx_full hold rule.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Backpressure: wr_uart is never asserted while tx_full=1. Byte order and value are held unchanged across stalls.
- start while busy=1 is ignored; it is neither queued nor able to alter the captured value.
- Latency, with start accepted at cycle t, unsigned, tx_full=0:
  - First write at t+1+N+s, where s = number of suppressed leading zeros.
  - Consecutive writes are back-to-back thereafter.
- Width: BCD register is 4*D bits; mag register is N bits; counter is clog2(N+1) bits.

Decomposition:
- Shared package alu_uart_pkg:
  - ASCII constants: ASCII_ZERO=48, ASCII_MINUS=45, ASCII_CR=13, ASCII_LF=10.
  - State encoding localparams for this FSM.
  - The ALU opcode constants already used by the interface FSM.
- One natural sub-module: bin2bcd_dd.
  - Iterative double-dabble core with load/step/done.
  - Parameterised by N and D.
  - Instantiated by the CONV state.

Test Plan:
- N=8, alu_in=0, start -> bytes 48,13,10 on three consecutive wr_uart cycles; done pulse one cycle after LF.
- alu_in=255 -> 50,53,53,13,10; first write exactly 9 cycles after the start cycle; alu_in=7 -> 55,13,10 (two zeros suppressed, first write at t+11).
- alu_in=128, tx_full held high for 5 cycles after the first write -> no wr_uart during the stall; sequence resumes 50,56,13,10 with no lost or duplicated bytes.
- SIGNED=1, alu_in=8'h80 -> 45,49,50,56,13,10; alu_in=8'hFF -> 45,49,13,10.
- start=1 with alu_in=99 pulsed during EMIT of the value 200 -> output is exactly 50,48,48,13,10; no second string follows.
- reset=0 for one cycle after the second digit of 255 -> wr_uart=0, busy=0 from the next cycle; a subsequent start with alu_in=3 yields 51,13,10.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared constants for the UART/ALU interface: ASCII codes, ALU opcodes and
// the state encoding of the result transmit sequencer.
package alu_uart_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_MINUS = 8'd45;
    localparam logic [7:0] ASCII_CR    = 8'd13;
    localparam logic [7:0] ASCII_LF    = 8'd10;

    // Opcodes decoded by the interface FSM that drives the ALU.
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SIGN    = 3'd1,
        ST_CONV    = 3'd2,
        ST_EMIT    = 3'd3,
        ST_TERM_CR = 3'd4,
        ST_TERM_LF = 3'd5,
        ST_DONE    = 3'd6
    } tx_state_t;

endpackage

// File: rtl/bin2bcd_dd.sv
// Iterative double-dabble converter: load captures an N-bit magnitude, each
// step performs one add-3/shift iteration; last flags the final iteration.
module bin2bcd_dd #(
    parameter int N = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [N-1:0]   load_val,
    input  logic           step,
    output logic [4*D-1:0] bcd,
    output logic           last
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]   mag_q, mag_d;
    logic [4*D-1:0] bcd_q, bcd_d;
    logic [4*D-1:0] adj;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        mag_d = mag_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        adj   = bcd_q;
        for (int i = 0; i < D; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        if (load) begin
            mag_d = load_val;
            bcd_d = '0;
            cnt_d = CW'(N);
        end else if (step && (cnt_q != '0)) begin
            {bcd_d, mag_d} = {adj, mag_q} << 1;
            cnt_d          = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mag_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            mag_q <= mag_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bcd  = bcd_q;
    // High during the iteration that brings the counter to zero.
    assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_result_tx.sv
// Converts a captured ALU result to decimal ASCII (optional sign, CR/LF) and
// streams it into the UART TX FIFO, stalling on tx_full.
module alu_result_tx
    import alu_uart_pkg::*;
#(
    parameter int N      = 8,
    parameter int D      = 3,
    parameter int SIGNED = 0,
    parameter int CRLF   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] alu_in,
    input  logic         tx_full,
    output logic         wr_uart,
    output logic [7:0]   uart_out,
    output logic         busy,
    output logic         done,
    output logic [2:0]   dbg_state
);

    localparam int KW = (D > 1) ? $clog2(D) : 1;

    // Handshake: a byte transfers in every cycle where wr_uart=1; wr_uart is
    // only raised when tx_full=0, and uart_out is stable until it transfers.

    tx_state_t      state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic           emitted_q, emitted_d;

    logic           load, step, last, neg_in;
    logic [N-1:0]   load_val;
    logic [4*D-1:0] bcd;
    logic [3:0]     digit;

    bin2bcd_dd #(.N(N), .D(D)) u_bcd (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .bcd      (bcd),
        .last     (last)
    );

    assign neg_in   = (SIGNED != 0) && alu_in[N-1];
    assign load_val = neg_in ? (~alu_in + 1'b1) : alu_in;
    assign digit    = bcd[{k_q, 2'b00} +: 4];

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        emitted_d = emitted_q;
        wr_uart   = 1'b0;
        uart_out  = 8'd0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    k_d       = KW'(D - 1);
                    emitted_d = 1'b0;
                    state_d   = neg_in ? ST_SIGN : ST_CONV;
                end
            end
            ST_SIGN: begin
                uart_out = ASCII_MINUS;
                wr_uart  = ~tx_full;
                if (!tx_full) state_d = ST_CONV;
            end
            ST_CONV: begin
                step = 1'b1;
                if (last) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                // Leading zeros cost one silent cycle each; digit 0 always prints.
                if (!emitted_q && (digit == 4'd0) && (k_q != '0)) begin
                    k_d = k_q - 1'b1;
                end else begin
                    uart_out = ASCII_ZERO + {4'h0, digit};
                    wr_uart  = ~tx_full;
                    if (!tx_full) begin
                        emitted_d = 1'b1;
                        if (k_q == '0) state_d = (CRLF != 0) ? ST_TERM_CR : ST_DONE;
                        else           k_d     = k_q - 1'b1;
                    end
                end
            end
            ST_TERM_CR: begin
                uart_out = ASCII_CR;
                wr_uart  = ~tx_full;
                if (!tx_full) state_d = ST_TERM_LF;
            end
            ST_TERM_LF: begin
                uart_out = ASCII_LF;
                wr_uart  = ~tx_full;
                if (!tx_full) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            emitted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            emitted_q <= emitted_d;
        end
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: an unsigned and a signed instance, each
// with a byte scoreboard fed by hand-computed expected strings.
`timescale 1ns/1ps
module tb_alu_result_tx;
  import alu_uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_full = 1'b0;
  logic       start_u = 1'b0, start_s = 1'b0;
  logic [7:0] alu_u = 8'd0, alu_s = 8'd0;
  logic       wr_u, wr_s, busy_u, busy_s, done_u, done_s;
  logic [7:0] out_u, out_s;
  logic [2:0] st_u, st_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc, first_cyc_u, last_cyc_u, done_cyc;
  int wr_cnt_u = 0, wr_cnt_s = 0;
  bit first_pend_u = 1'b0;
  logic [7:0] exp_u_q[$];
  logic [7:0] exp_s_q[$];

  alu_result_tx #(.N(8), .D(3), .SIGNED(0), .CRLF(1)) u_dut (
    .clk(clk), .reset(reset), .start(start_u), .alu_in(alu_u), .tx_full(tx_full),
    .wr_uart(wr_u), .uart_out(out_u), .busy(busy_u), .done(done_u), .dbg_state(st_u)
  );

  alu_result_tx #(.N(8), .D(3), .SIGNED(1), .CRLF(1)) s_dut (
    .clk(clk), .reset(reset), .start(start_s), .alu_in(alu_s), .tx_full(tx_full),
    .wr_uart(wr_s), .uart_out(out_s), .busy(busy_s), .done(done_s), .dbg_state(st_s)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboards
  always @(negedge clk) begin
    if (wr_u) begin
      if (first_pend_u) begin
        first_cyc_u = cyc;
        first_pend_u = 1'b0;
      end
      last_cyc_u = cyc;
      wr_cnt_u++;
      check("u_wr_while_full", tx_full, 0);
      check("u_byte_expected", exp_u_q.size() > 0, 1);
      if (exp_u_q.size() > 0) check("u_byte", out_u, exp_u_q.pop_front());
    end
    if (wr_s) begin
      wr_cnt_s++;
      check("s_wr_while_full", tx_full, 0);
      check("s_byte_expected", exp_s_q.size() > 0, 1);
      if (exp_s_q.size() > 0) check("s_byte", out_s, exp_s_q.pop_front());
    end
  end

  // drivers (called aligned to posedge+1)
  task automatic pulse_start(bit sgn, logic [7:0] v);
    if (sgn) begin
      start_s = 1'b1;
      alu_s = v;
    end else begin
      start_u = 1'b1;
      alu_u = v;
      first_pend_u = 1'b1;
    end
    start_cyc = cyc;
    @(posedge clk); #1;
    start_u = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_done(bit sgn, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sgn ? done_s : done_u) && n < budget);
    check(sgn ? "s_done_seen" : "u_done_seen", sgn ? done_s : done_u, 1);
    done_cyc = cyc;
    @(posedge clk); #1;
    check(sgn ? "s_done_one_cycle" : "u_done_one_cycle", sgn ? done_s : done_u, 0);
  endtask

  task automatic wait_wr_u(int budget);
    int n = 0;
    @(negedge clk);
    while (!wr_u && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("u_wr_seen", wr_u, 1);
  endtask

  initial begin
    int base;
    int seen;
    int n;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr", wr_u, 0);
    check("rst_out", out_u, 0);
    check("rst_busy", busy_u, 0);
    check("rst_done", done_u, 0);
    check("rst_state", st_u, ST_IDLE);
    check("rst_s_wr", wr_s, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 0 -> "0\r\n", two zeros suppressed
    exp_u_q.push_back(8'd48); exp_u_q.push_back(8'd13); exp_u_q.push_back(8'd10);
    pulse_start(1'b0, 8'd0);
    @(negedge clk);
    check("zero_busy", busy_u, 1);
    wait_done(1'b0, 40);
    check("zero_latency", first_cyc_u - start_cyc, 11);
    check("zero_b2b", last_cyc_u - first_cyc_u, 2);
    check("zero_done_after_lf", done_cyc - last_cyc_u, 1);
    check("zero_drained", exp_u_q.size(), 0);

    // 255 -> "255\r\n"
    exp_u_q.push_back(8'd50); exp_u_q.push_back(8'd53); exp_u_q.push_back(8'd53);
    exp_u_q.push_back(8'd13); exp_u_q.push_back(8'd10);
    pulse_start(1'b0, 8'd255);
    wait_done(1'b0, 40);
    check("ff_latency", first_cyc_u - start_cyc, 9);
    check("ff_b2b", last_cyc_u - first_cyc_u, 4);
    check("ff_drained", exp_u_q.size(), 0);

    // 7 -> "7\r\n"
    exp_u_q.push_back(8'd55); exp_u_q.push_back(8'd13); exp_u_q.push_back(8'd10);
    pulse_start(1'b0, 8'd7);
    wait_done(1'b0, 40);
    check("seven_latency", first_cyc_u - start_cyc, 11);
    check("seven_drained", exp_u_q.size(), 0);

    // 128 with a 5-cycle stall after the first byte
    exp_u_q.push_back(8'd49); exp_u_q.push_back(8'd50); exp_u_q.push_back(8'd56);
    exp_u_q.push_back(8'd13); exp_u_q.push_back(8'd10);
    base = wr_cnt_u;
    pulse_start(1'b0, 8'd128);
    wait_wr_u(40);
    @(posedge clk); #1;
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_no_wr", wr_u, 0);
      check("stall_hold_byte", out_u, 50);
      check("stall_busy", busy_u, 1);
      @(posedge clk); #1;
    end
    tx_full = 1'b0;
    wait_done(1'b0, 40);
    check("stall_count", wr_cnt_u - base, 5);
    check("stall_drained", exp_u_q.size(), 0);

    // 200 with a start(99) pulsed during EMIT
    exp_u_q.push_back(8'd50); exp_u_q.push_back(8'd48); exp_u_q.push_back(8'd48);
    exp_u_q.push_back(8'd13); exp_u_q.push_back(8'd10);
    base = wr_cnt_u;
    pulse_start(1'b0, 8'd200);
    wait_wr_u(40);
    @(posedge clk); #1;
    start_u = 1'b1;
    alu_u = 8'd99;
    @(posedge clk); #1;
    start_u = 1'b0;
    wait_done(1'b0, 40);
    repeat (20) @(posedge clk);
    #1;
    check("busy_start_count", wr_cnt_u - base, 5);
    check("busy_start_idle", busy_u, 0);
    check("busy_start_drained", exp_u_q.size(), 0);

    // reset after the second digit of 255
    exp_u_q.push_back(8'd50); exp_u_q.push_back(8'd53);
    base = wr_cnt_u;
    pulse_start(1'b0, 8'd255);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (wr_u) seen++;
    end
    check("rst_mid_two_bytes", seen, 2);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_wr", wr_u, 0);
    check("rst_mid_busy", busy_u, 0);
    check("rst_mid_state", st_u, ST_IDLE);
    repeat (15) @(posedge clk);
    #1;
    check("rst_mid_count", wr_cnt_u - base, 2);
    check("rst_mid_drained", exp_u_q.size(), 0);

    // 3 -> "3\r\n" after the abandoned string
    exp_u_q.push_back(8'd51); exp_u_q.push_back(8'd13); exp_u_q.push_back(8'd10);
    pulse_start(1'b0, 8'd3);
    wait_done(1'b0, 40);
    check("three_latency", first_cyc_u - start_cyc, 11);
    check("three_drained", exp_u_q.size(), 0);

    // signed: 0x80 -> "-128\r\n"
    exp_s_q.push_back(8'd45); exp_s_q.push_back(8'd49); exp_s_q.push_back(8'd50);
    exp_s_q.push_back(8'd56); exp_s_q.push_back(8'd13); exp_s_q.push_back(8'd10);
    base = wr_cnt_s;
    pulse_start(1'b1, 8'h80);
    wait_done(1'b1, 40);
    check("s80_count", wr_cnt_s - base, 6);
    check("s80_drained", exp_s_q.size(), 0);

    // signed: 0xFF -> "-1\r\n"
    exp_s_q.push_back(8'd45); exp_s_q.push_back(8'd49);
    exp_s_q.push_back(8'd13); exp_s_q.push_back(8'd10);
    base = wr_cnt_s;
    pulse_start(1'b1, 8'hFF);
    wait_done(1'b1, 40);
    check("sff_count", wr_cnt_s - base, 4);
    check("sff_drained", exp_s_q.size(), 0);
    check("u_quiet_during_signed", busy_u, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
